riptide_dcache: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache.
- Acts as the responder on the RIPTIDE-II core's data/IO bus: address, data_out, IO_WC, IO_RC, IO_n_LB_w and IO_n_LB_r come in; data_in and d_cache_miss go back.
- Core-side inputs are named after the core's own outputs they connect to (the core's address/data_out map to cpu_address/cpu_data_out).
- Sits between the core and the SDRAM controller's word port. Line fills and buffered writes use a req/ack handshake.

---
 rtl/riptide_dcache_pkg.sv | 18 +
 rtl/dcache_data_ram.sv | 36 +++
 rtl/riptide_dcache.sv | 166 ++++++++++++++++
 tb/tb_riptide_dcache.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riptide_dcache_pkg.sv
// Shared geometry and FSM encoding for the RIPTIDE-II direct-mapped data cache.
package riptide_dcache_pkg;
   localparam int LINES      = 16;
   localparam int LINE_WORDS = 4;
   localparam int ADDR_W     = 16;
   localparam int DATA_W     = 16;
   localparam int OFS_W      = $clog2(LINE_WORDS);
   localparam int IDX_W      = $clog2(LINES);
   localparam int TAG_W      = ADDR_W - IDX_W - OFS_W;
   localparam int RAM_AW     = IDX_W + OFS_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      FILL  = 2'd2,
      DATA  = 2'd3
   } state_t;
endpackage

// File: rtl/dcache_data_ram.sv
// Byte-enabled 16-bit RAM, one write and one read port; read-before-write, 1-cycle read latency.
// Read data register holds its value between reads; no backpressure.
module dcache_data_ram
   import riptide_dcache_pkg::*;
#(
   parameter int DEPTH = LINES * LINE_WORDS,
   parameter int AW    = RAM_AW
) (
   input  logic              clk,
   input  logic              n_reset,
   input  logic              i_we,
   input  logic [AW-1:0]     i_waddr,
   input  logic [1:0]        i_wbe,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_re,
   input  logic [AW-1:0]     i_raddr,
   output logic [DATA_W-1:0] o_rdata
);
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) begin
         if (i_wbe[1]) r_mem[i_waddr][15:8] <= i_wdata[15:8];
         if (i_wbe[0]) r_mem[i_waddr][7:0]  <= i_wdata[7:0];
      end
   end

   // Same-edge read of a word being written returns the old contents.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset)  r_rdata <= '0;
      else if (i_re) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;
endmodule

// File: rtl/riptide_dcache.sv
// Direct-mapped write-through no-write-allocate D-cache; read hit 1 cycle, one-entry write buffer.
// Misses and writes against a full buffer or busy FSM stall the core through d_cache_miss.
module riptide_dcache
   import riptide_dcache_pkg::*;
(
   input  logic              clk,
   input  logic              n_reset,
   input  logic [ADDR_W-1:0] cpu_address,
   input  logic [DATA_W-1:0] cpu_data_out,
   input  logic              IO_WC,
   input  logic              IO_RC,
   input  logic              IO_n_LB_w,
   input  logic              IO_n_LB_r,
   output logic [DATA_W-1:0] data_in,
   output logic              d_cache_miss,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [1:0]        mem_be,
   input  logic              mem_ack,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata
);
   state_t            r_state;
   logic [LINES-1:0]  r_valid;
   logic [TAG_W-1:0]  r_tag [LINES];
   logic              r_wb_full;
   logic [ADDR_W-1:0] r_fill_addr;
   logic [OFS_W-1:0]  r_cnt;
   logic              r_mem_req;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic [1:0]        r_mem_be;

   logic [OFS_W-1:0]  w_ofs;
   logic [IDX_W-1:0]  w_idx;
   logic [TAG_W-1:0]  w_tag;
   logic [IDX_W-1:0]  w_fill_idx;
   logic              w_idle;
   logic              w_hit;
   logic [1:0]        w_be;
   logic              w_wr_acc;
   logic              w_cpu_wr_hit;
   logic              w_rd_hit;
   logic              w_fill_wr;
   logic              w_fill_last;
   logic              w_ram_we;
   logic [RAM_AW-1:0] w_ram_waddr;
   logic [1:0]        w_ram_wbe;
   logic [DATA_W-1:0] w_ram_wdata;
   logic              w_unused;

   // The core selects the read byte lane itself.
   assign w_unused = IO_n_LB_r;

   assign w_ofs      = cpu_address[OFS_W-1:0];
   assign w_idx      = cpu_address[OFS_W +: IDX_W];
   assign w_tag      = cpu_address[ADDR_W-1 -: TAG_W];
   assign w_fill_idx = r_fill_addr[OFS_W +: IDX_W];

   assign w_idle       = (r_state == IDLE);
   assign w_hit        = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_be         = IO_n_LB_w ? 2'b01 : 2'b10;
   assign w_wr_acc     = IO_WC && w_idle && !r_wb_full;
   assign w_cpu_wr_hit = w_wr_acc && w_hit;
   assign w_rd_hit     = IO_RC && w_hit && w_idle;
   assign w_fill_wr    = (r_state == DATA) && mem_rvalid;
   assign w_fill_last  = w_fill_wr && (r_cnt == OFS_W'(LINE_WORDS - 1));

   assign d_cache_miss = (IO_RC && !(w_hit && w_idle)) || (IO_WC && (r_wb_full || !w_idle));

   // Fill and CPU writes never coincide: CPU writes land only in IDLE.
   assign w_ram_we    = w_fill_wr || w_cpu_wr_hit;
   assign w_ram_waddr = w_fill_wr ? {w_fill_idx, r_cnt} : {w_idx, w_ofs};
   assign w_ram_wbe   = w_fill_wr ? 2'b11 : w_be;
   assign w_ram_wdata = w_fill_wr ? mem_rdata : cpu_data_out;

   dcache_data_ram #(
      .DEPTH (LINES * LINE_WORDS),
      .AW    (RAM_AW)
   ) u_data_ram (
      .clk     (clk),
      .n_reset (n_reset),
      .i_we    (w_ram_we),
      .i_waddr (w_ram_waddr),
      .i_wbe   (w_ram_wbe),
      .i_wdata (w_ram_wdata),
      .i_re    (w_rd_hit),
      .i_raddr ({w_idx, w_ofs}),
      .o_rdata (data_in)
   );

   always_ff @(posedge clk) begin
      if (w_fill_last) r_tag[w_fill_idx] <= r_fill_addr[ADDR_W-1 -: TAG_W];
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_state     <= IDLE;
         r_valid     <= '0;
         r_wb_full   <= 1'b0;
         r_fill_addr <= '0;
         r_cnt       <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_be    <= '0;
      end else begin
         if (r_mem_req && mem_ack) begin
            r_mem_req <= 1'b0;
            if (r_mem_we) r_wb_full <= 1'b0;
         end
         // The write buffer is the request register itself.
         if (w_wr_acc) begin
            r_wb_full   <= 1'b1;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= cpu_address;
            r_mem_wdata <= cpu_data_out;
            r_mem_be    <= w_be;
         end
         case (r_state)
            IDLE: begin
               if (IO_RC && !w_hit) begin
                  r_fill_addr <= cpu_address;
                  r_state     <= (r_wb_full || w_wr_acc) ? DRAIN : FILL;
               end
            end
            DRAIN: begin
               if (!r_wb_full || mem_ack) r_state <= FILL;
            end
            FILL: begin
               if (!r_mem_req) begin
                  r_mem_req  <= 1'b1;
                  r_mem_we   <= 1'b0;
                  r_mem_addr <= {r_fill_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
                  r_mem_be   <= 2'b11;
               end else if (mem_ack) begin
                  r_valid[w_fill_idx] <= 1'b0;
                  r_cnt               <= '0;
                  r_state             <= DATA;
               end
            end
            DATA: begin
               if (mem_rvalid) begin
                  r_cnt <= r_cnt + 1'b1;
                  if (w_fill_last) begin
                     r_valid[w_fill_idx] <= 1'b1;
                     r_state             <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign mem_be    = r_mem_be;
endmodule

// File: tb/tb_riptide_dcache.sv
// Directed bench for riptide_dcache with a word-addressed memory model behind the req/ack port.
module tb_riptide_dcache;
   import riptide_dcache_pkg::*;

   logic        clk = 1'b0;
   logic        n_reset;
   logic [15:0] cpu_address, cpu_data_out;
   logic        IO_WC, IO_RC, IO_n_LB_w, IO_n_LB_r;
   logic [15:0] data_in;
   logic        d_cache_miss;
   logic        mem_req, mem_we;
   logic [15:0] mem_addr, mem_wdata;
   logic [1:0]  mem_be;
   logic        mem_ack, mem_rvalid;
   logic [15:0] mem_rdata;

   always #5 clk = ~clk;

   riptide_dcache dut (
      .clk          (clk),
      .n_reset      (n_reset),
      .cpu_address  (cpu_address),
      .cpu_data_out (cpu_data_out),
      .IO_WC        (IO_WC),
      .IO_RC        (IO_RC),
      .IO_n_LB_w    (IO_n_LB_w),
      .IO_n_LB_r    (IO_n_LB_r),
      .data_in      (data_in),
      .d_cache_miss (d_cache_miss),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_be       (mem_be),
      .mem_ack      (mem_ack),
      .mem_rvalid   (mem_rvalid),
      .mem_rdata    (mem_rdata)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Memory model: word i holds 0xA000 + (i mod 4) until written.
   logic [15:0] mdl [65536];
   logic        log_we   [$];
   logic [15:0] log_addr [$];
   logic [15:0] log_data [$];
   logic [1:0]  log_be   [$];
   int          ack_delay  = 0;
   int          req_cnt    = 0;
   int          burst_left = 0;
   int          rv_count   = 0;
   logic [15:0] burst_addr = '0;

   initial begin
      for (int i = 0; i < 65536; i++) mdl[i] = 16'hA000 | 16'(i & 3);
      mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      forever begin
         @(negedge clk);
         mem_ack = 1'b0;
         mem_rvalid = 1'b0;
         if (!n_reset) begin
            burst_left = 0;
            req_cnt = 0;
         end else if (burst_left > 0) begin
            mem_rvalid = 1'b1;
            mem_rdata = mdl[burst_addr];
            burst_addr = burst_addr + 16'd1;
            burst_left--;
            rv_count++;
         end else if (mem_req) begin
            if (req_cnt >= ack_delay) begin
               mem_ack = 1'b1;
               req_cnt = 0;
               log_we.push_back(mem_we);
               log_addr.push_back(mem_addr);
               log_data.push_back(mem_wdata);
               log_be.push_back(mem_be);
               if (mem_we) begin
                  if (mem_be[1]) mdl[mem_addr][15:8] = mem_wdata[15:8];
                  if (mem_be[0]) mdl[mem_addr][7:0] = mem_wdata[7:0];
               end else begin
                  burst_left = LINE_WORDS;
                  burst_addr = mem_addr;
               end
            end else begin
               req_cnt++;
            end
         end
      end
   end

   task automatic do_read(input logic [15:0] a, output logic [15:0] d, output logic first_miss);
      int stall = 0;
      cpu_address = a;
      IO_RC = 1'b1;
      #1;
      first_miss = d_cache_miss;
      while (d_cache_miss && stall < 200) begin
         @(negedge clk); #2;
         stall++;
      end
      if (d_cache_miss) check("rd_timeout", d_cache_miss, 1'b0);
      @(posedge clk);
      @(negedge clk); #1;
      IO_RC = 1'b0;
      d = data_in;
   endtask

   task automatic do_write(input logic [15:0] a, input logic [15:0] dat, input logic lbw, output int stall);
      stall = 0;
      cpu_address = a;
      cpu_data_out = dat;
      IO_n_LB_w = lbw;
      IO_WC = 1'b1;
      #1;
      while (d_cache_miss && stall < 200) begin
         @(negedge clk); #2;
         stall++;
      end
      if (d_cache_miss) check("wr_timeout", d_cache_miss, 1'b0);
      @(posedge clk);
      @(negedge clk); #1;
      IO_WC = 1'b0;
   endtask

   task automatic wait_log(input int n);
      int w = 0;
      while (log_addr.size() < n && w < 200) begin
         @(negedge clk); #2;
         w++;
      end
      check("log_wait", log_addr.size() >= n, 1'b1);
      @(negedge clk); #1;
   endtask

   initial begin
      logic [15:0] d;
      logic        fm;
      int          nl, rv0, st1, st2, w;
      n_reset = 1'b1;
      cpu_address = '0; cpu_data_out = '0;
      IO_WC = 1'b0; IO_RC = 1'b0; IO_n_LB_w = 1'b0; IO_n_LB_r = 1'b0;
      #2 n_reset = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_data_in", data_in, 16'h0);
      check("rst_miss", d_cache_miss, 1'b0);
      check("rst_req", mem_req, 1'b0);
      check("rst_we", mem_we, 1'b0);
      check("rst_addr", mem_addr, 16'h0);
      check("rst_wdata", mem_wdata, 16'h0);
      check("rst_be", mem_be, 2'b00);
      n_reset = 1'b1;
      @(negedge clk); #1;

      // Cold miss fills line 0x0120..0x0123.
      nl = log_addr.size(); rv0 = rv_count;
      do_read(16'h0123, d, fm);
      check("fill_miss", fm, 1'b1);
      check("fill_nreq", log_addr.size() - nl, 1);
      check("fill_addr", log_addr[nl], 16'h0120);
      check("fill_we", log_we[nl], 1'b0);
      check("fill_words", rv_count - rv0, 4);
      check("fill_data", d, 16'hA003);

      nl = log_addr.size();
      do_read(16'h0121, d, fm);
      check("hit_miss", fm, 1'b0);
      check("hit_data", d, 16'hA001);
      check("hit_noreq", log_addr.size() - nl, 0);

      // High-byte write hit, written through.
      nl = log_addr.size();
      do_write(16'h0121, 16'h5A5A, 1'b0, st1);
      check("wr_stall", st1, 0);
      wait_log(nl + 1);
      check("wr_we", log_we[nl], 1'b1);
      check("wr_addr", log_addr[nl], 16'h0121);
      check("wr_data", log_data[nl], 16'h5A5A);
      check("wr_be", log_be[nl], 2'b10);
      do_read(16'h0121, d, fm);
      check("wr_rd_miss", fm, 1'b0);
      check("wr_rd_data", d, 16'h5A01);

      // Same-cycle read and write of one word: old word returned.
      nl = log_addr.size();
      cpu_address = 16'h0120; cpu_data_out = 16'h7777; IO_n_LB_w = 1'b1;
      IO_RC = 1'b1; IO_WC = 1'b1;
      #1;
      check("rw_miss", d_cache_miss, 1'b0);
      @(posedge clk);
      @(negedge clk); #1;
      IO_RC = 1'b0; IO_WC = 1'b0;
      check("rw_old", data_in, 16'hA000);
      wait_log(nl + 1);
      do_read(16'h0120, d, fm);
      check("rw_new", d, 16'hA077);

      // Back-to-back writes against a slow ack.
      ack_delay = 5;
      nl = log_addr.size();
      do_write(16'h0122, 16'h1111, 1'b1, st1);
      do_write(16'h0123, 16'h2222, 1'b0, st2);
      check("bb_first_nostall", st1, 0);
      check("bb_second_stall", st2 >= 5, 1'b1);
      wait_log(nl + 2);
      check("bb_addr0", log_addr[nl], 16'h0122);
      check("bb_be0", log_be[nl], 2'b01);
      check("bb_addr1", log_addr[nl + 1], 16'h0123);
      check("bb_be1", log_be[nl + 1], 2'b10);
      do_read(16'h0122, d, fm);
      check("bb_rd0", d, 16'hA011);
      do_read(16'h0123, d, fm);
      check("bb_rd1", d, 16'h2203);

      // Write miss then read of the same word: drain before fill, no allocate.
      ack_delay = 3;
      nl = log_addr.size();
      do_write(16'h0300, 16'hBEEF, 1'b1, st1);
      do_read(16'h0300, d, fm);
      check("wm_rd_miss", fm, 1'b1);
      check("wm_nreq", log_addr.size() - nl, 2);
      check("wm_first_we", log_we[nl], 1'b1);
      check("wm_first_addr", log_addr[nl], 16'h0300);
      check("wm_second_we", log_we[nl + 1], 1'b0);
      check("wm_second_addr", log_addr[nl + 1], 16'h0300);
      check("wm_data", d, 16'hA0EF);

      // Reset during the second word of a fill.
      ack_delay = 0;
      rv0 = rv_count;
      cpu_address = 16'h0400;
      IO_RC = 1'b1;
      w = 0;
      while (rv_count < rv0 + 2 && w < 200) begin
         @(negedge clk); #2;
         w++;
      end
      check("mid_fill_reached", rv_count - rv0, 2);
      n_reset = 1'b0;
      IO_RC = 1'b0;
      #1;
      check("mr_data_in", data_in, 16'h0);
      check("mr_miss", d_cache_miss, 1'b0);
      check("mr_req", mem_req, 1'b0);
      check("mr_we", mem_we, 1'b0);
      check("mr_addr", mem_addr, 16'h0);
      check("mr_wdata", mem_wdata, 16'h0);
      check("mr_be", mem_be, 2'b00);
      @(negedge clk); #1;
      n_reset = 1'b1;
      @(negedge clk); #1;
      nl = log_addr.size(); rv0 = rv_count;
      do_read(16'h0400, d, fm);
      check("rf_miss", fm, 1'b1);
      check("rf_addr", log_addr[nl], 16'h0400);
      check("rf_words", rv_count - rv0, 4);
      check("rf_data", d, 16'hA000);
      do_read(16'h0121, d, fm);
      check("rf_old_line_miss", fm, 1'b1);
      check("rf_old_line_data", d, 16'h5A01);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: sim time exceeded, checks %0d", n_checks);
      $fatal(1);
   end
endmodule
